// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-channel alarm handler.
package alarm_pkg;

  localparam int WEEKDAY_W  = 3;
  localparam int DAY_MASK_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RINGING,
    SNOOZED
  } alarm_state_t;

  typedef struct packed {
    logic [7:0]            sec;
    logic [7:0]            min;
    logic [7:0]            hour;
    logic [DAY_MASK_W-1:0] day_mask;
    logic                  enable;
  } alarm_cfg_t;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: config registers, state machine, ring/snooze counters.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int SNOOZE_TICKS = 300,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZES  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [7:0]           cur_sec,
  input  logic [7:0]           cur_min,
  input  logic [7:0]           cur_hour,
  input  logic [WEEKDAY_W-1:0] cur_weekday,
  input  logic                 cfg_load,
  input  alarm_cfg_t           cfg,
  input  logic                 snooze,
  input  logic                 stop,
  output logic                 ringing,
  output logic                 snoozed
);

  localparam int RING_W = (RING_TIMEOUT < 1) ? 1 : $clog2(RING_TIMEOUT + 1);
  localparam int SNZ_W  = (SNOOZE_TICKS < 1) ? 1 : $clog2(SNOOZE_TICKS + 1);
  localparam int NUM_W  = (MAX_SNOOZES < 1)  ? 1 : $clog2(MAX_SNOOZES + 1);

  localparam logic [RING_W-1:0] RING_LAST  = RING_W'(RING_TIMEOUT - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST   = SNZ_W'(SNOOZE_TICKS - 1);
  localparam logic [NUM_W-1:0]  SNZ_LIMIT  = NUM_W'(MAX_SNOOZES);

  alarm_state_t      state;
  alarm_cfg_t        cfg_reg;
  logic [RING_W-1:0] ring_cnt;
  logic [SNZ_W-1:0]  snooze_cnt;
  logic [NUM_W-1:0]  snooze_num;
  logic [7:0]        mask_ext;
  logic              match;

  // Tick-qualified time/day match; weekday 7 lands on the always-zero pad bit.
  always_comb begin
    mask_ext = {1'b0, cfg_reg.day_mask};
    match    = tick && cfg_reg.enable &&
               (cfg_reg.sec == cur_sec) && (cfg_reg.min == cur_min) &&
               (cfg_reg.hour == cur_hour) && mask_ext[cur_weekday];
  end

  // Channel FSM with registered status flags; a config write overrides all events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cfg_reg    <= '0;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      snooze_num <= '0;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
    end else if (cfg_load) begin
      cfg_reg    <= cfg;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      snooze_num <= '0;
      state      <= cfg.enable ? ARMED : IDLE;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (match) begin
            state    <= RINGING;
            ring_cnt <= '0;
            ringing  <= 1'b1;
          end
        end
        RINGING: begin
          if (stop || (snooze && snooze_num == SNZ_LIMIT)) begin
            state      <= ARMED;
            snooze_num <= '0;
            ringing    <= 1'b0;
          end else if (snooze) begin
            state      <= SNOOZED;
            snooze_num <= snooze_num + 1'b1;
            snooze_cnt <= '0;
            ringing    <= 1'b0;
            snoozed    <= 1'b1;
          end else if (tick && ring_cnt == RING_LAST) begin
            state      <= ARMED;
            snooze_num <= '0;
            ringing    <= 1'b0;
          end else if (tick) begin
            ring_cnt <= ring_cnt + 1'b1;
          end
        end
        SNOOZED: begin
          if (stop) begin
            state      <= ARMED;
            snooze_num <= '0;
            snoozed    <= 1'b0;
          end else if (tick && snooze_cnt == SNZ_LAST) begin
            state    <= RINGING;
            ring_cnt <= '0;
            ringing  <= 1'b1;
            snoozed  <= 1'b0;
          end else if (tick) begin
            snooze_cnt <= snooze_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_alarm_handler.sv
// Multi-channel alarm handler: config decode, channel array, buzzer merge, priority encode.
module multi_alarm_handler
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_TICKS = 300,
  parameter int RING_TIMEOUT = 60,
  parameter int MAX_SNOOZES  = 3,
  localparam int IDX_W = (NUM_ALARMS <= 1) ? 1 : $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [7:0]            cur_sec,
  input  logic [7:0]            cur_min,
  input  logic [7:0]            cur_hour,
  input  logic [WEEKDAY_W-1:0]  cur_weekday,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [7:0]            cfg_sec,
  input  logic [7:0]            cfg_min,
  input  logic [7:0]            cfg_hour,
  input  logic [DAY_MASK_W-1:0] cfg_day_mask,
  input  logic                  cfg_enable,
  input  logic                  snooze,
  input  logic                  stop,
  output logic [NUM_ALARMS-1:0] ringing_vec,
  output logic [NUM_ALARMS-1:0] snoozed_vec,
  output logic                  alarm_buzzer,
  output logic [IDX_W-1:0]      active_idx
);

  alarm_cfg_t cfg_in;

  // Pack the config bus once for all channels.
  always_comb begin
    cfg_in = '{sec: cfg_sec, min: cfg_min, hour: cfg_hour,
               day_mask: cfg_day_mask, enable: cfg_enable};
  end

  // Out-of-range indices never equal any channel number, so such writes drop.
  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    alarm_channel #(
      .SNOOZE_TICKS(SNOOZE_TICKS),
      .RING_TIMEOUT(RING_TIMEOUT),
      .MAX_SNOOZES (MAX_SNOOZES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .cur_sec    (cur_sec),
      .cur_min    (cur_min),
      .cur_hour   (cur_hour),
      .cur_weekday(cur_weekday),
      .cfg_load   (cfg_we && (cfg_idx == IDX_W'(g))),
      .cfg        (cfg_in),
      .snooze     (snooze),
      .stop       (stop),
      .ringing    (ringing_vec[g]),
      .snoozed    (snoozed_vec[g])
    );
  end

  // Buzzer and lowest-index priority encode over the registered ringing flags.
  always_comb begin
    logic found;
    found        = 1'b0;
    active_idx   = '0;
    alarm_buzzer = |ringing_vec;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (ringing_vec[i] && !found) begin
        active_idx = IDX_W'(i);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_handler.sv
// Directed bench for multi_alarm_handler (4-channel main DUT, 3-channel DUT for out-of-range writes).
module tb_multi_alarm_handler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] cur_sec = '0, cur_min = '0, cur_hour = '0;
  logic [2:0] cur_weekday = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_sec = '0, cfg_min = '0, cfg_hour = '0;
  logic [6:0] cfg_day_mask = '0;
  logic       cfg_enable = 1'b0;
  logic       snooze = 1'b0, stop = 1'b0;

  logic [3:0] ringing_vec, snoozed_vec;
  logic       alarm_buzzer;
  logic [1:0] active_idx;

  logic [2:0] ringing_vec3, snoozed_vec3;
  logic       alarm_buzzer3;
  logic [1:0] active_idx3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multi_alarm_handler #(
    .NUM_ALARMS(4), .SNOOZE_TICKS(5), .RING_TIMEOUT(60), .MAX_SNOOZES(3)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour), .cur_weekday(cur_weekday),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sec(cfg_sec), .cfg_min(cfg_min),
    .cfg_hour(cfg_hour), .cfg_day_mask(cfg_day_mask), .cfg_enable(cfg_enable),
    .snooze(snooze), .stop(stop),
    .ringing_vec(ringing_vec), .snoozed_vec(snoozed_vec),
    .alarm_buzzer(alarm_buzzer), .active_idx(active_idx)
  );

  multi_alarm_handler #(
    .NUM_ALARMS(3), .SNOOZE_TICKS(5), .RING_TIMEOUT(60), .MAX_SNOOZES(3)
  ) dut3 (
    .clk(clk), .reset(reset), .tick(tick),
    .cur_sec(cur_sec), .cur_min(cur_min), .cur_hour(cur_hour), .cur_weekday(cur_weekday),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sec(cfg_sec), .cfg_min(cfg_min),
    .cfg_hour(cfg_hour), .cfg_day_mask(cfg_day_mask), .cfg_enable(cfg_enable),
    .snooze(snooze), .stop(stop),
    .ringing_vec(ringing_vec3), .snoozed_vec(snoozed_vec3),
    .alarm_buzzer(alarm_buzzer3), .active_idx(active_idx3)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic [2:0] wd);
    cur_hour = h; cur_min = m; cur_sec = s; cur_weekday = wd;
  endtask

  task automatic write_cfg(input logic [1:0] idx, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input logic [6:0] mask, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_hour = h; cfg_min = m; cfg_sec = s;
    cfg_day_mask = mask; cfg_enable = en;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    cycle();
    snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    cycles(2);
    total_cnt++;
    if ({ringing_vec, snoozed_vec, alarm_buzzer, active_idx} !== 11'd0) begin
      $display("FAIL reset_state: got ring=%b snz=%b buz=%b idx=%0d, want all 0",
               ringing_vec, snoozed_vec, alarm_buzzer, active_idx);
    end else pass_cnt++;
    total_cnt++;
    if ({ringing_vec3, snoozed_vec3, alarm_buzzer3, active_idx3} !== 9'd0) begin
      $display("FAIL reset_state3: got ring=%b snz=%b, want 0", ringing_vec3, snoozed_vec3);
    end else pass_cnt++;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_basic_fire();
    set_time(8'd7, 8'd29, 8'd59, 3'd2);
    tick = 1'b1;
    write_cfg(2'd2, 8'd7, 8'd30, 8'd0, 7'h7F, 1'b1);
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b0000) begin
      $display("FAIL armed_no_ring: got %b, want 0000", ringing_vec);
    end else pass_cnt++;
    set_time(8'd7, 8'd30, 8'd0, 3'd2);
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b0100 || alarm_buzzer !== 1'b1 || active_idx !== 2'd2) begin
      $display("FAIL basic_fire: got ring=%b buz=%b idx=%0d, want 0100 1 2",
               ringing_vec, alarm_buzzer, active_idx);
    end else pass_cnt++;
    set_time(8'd7, 8'd30, 8'd1, 3'd2);
  endtask

  task automatic test_snooze();
    pulse_snooze();
    total_cnt++;
    if (snoozed_vec !== 4'b0100 || ringing_vec !== 4'b0000 || alarm_buzzer !== 1'b0) begin
      $display("FAIL snooze_enter: got snz=%b ring=%b buz=%b, want 0100 0000 0",
               snoozed_vec, ringing_vec, alarm_buzzer);
    end else pass_cnt++;
    for (int i = 1; i < 5; i++) begin
      cycle();
      total_cnt++;
      if (snoozed_vec !== 4'b0100 || alarm_buzzer !== 1'b0) begin
        $display("FAIL snooze_hold_%0d: got snz=%b buz=%b, want 0100 0", i, snoozed_vec, alarm_buzzer);
      end else pass_cnt++;
    end
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b0100 || snoozed_vec !== 4'b0000) begin
      $display("FAIL snooze_rering: got ring=%b snz=%b, want 0100 0000", ringing_vec, snoozed_vec);
    end else pass_cnt++;
  endtask

  task automatic test_snooze_limit();
    for (int n = 2; n <= 3; n++) begin
      pulse_snooze();
      cycles(5);
      total_cnt++;
      if (ringing_vec !== 4'b0100) begin
        $display("FAIL snooze_%0d_rering: got ring=%b, want 0100", n, ringing_vec);
      end else pass_cnt++;
    end
    pulse_snooze();
    total_cnt++;
    if (ringing_vec !== 4'b0000 || snoozed_vec !== 4'b0000 || alarm_buzzer !== 1'b0) begin
      $display("FAIL snooze_limit: got ring=%b snz=%b buz=%b, want 0000 0000 0",
               ringing_vec, snoozed_vec, alarm_buzzer);
    end else pass_cnt++;
    cycles(6);
    total_cnt++;
    if (ringing_vec !== 4'b0000 || snoozed_vec !== 4'b0000) begin
      $display("FAIL snooze_limit_hold: got ring=%b snz=%b, want 0000 0000", ringing_vec, snoozed_vec);
    end else pass_cnt++;
    set_time(8'd7, 8'd30, 8'd0, 3'd3);
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b0100 || active_idx !== 2'd2) begin
      $display("FAIL next_day_fire: got ring=%b idx=%0d, want 0100 2", ringing_vec, active_idx);
    end else pass_cnt++;
    set_time(8'd7, 8'd30, 8'd1, 3'd3);
    pulse_stop();
    total_cnt++;
    if (ringing_vec !== 4'b0000 || alarm_buzzer !== 1'b0) begin
      $display("FAIL stop: got ring=%b buz=%b, want 0000 0", ringing_vec, alarm_buzzer);
    end else pass_cnt++;
  endtask

  task automatic test_weekday_timeout();
    set_time(8'd7, 8'd30, 8'd0, 3'd7);
    cycles(2);
    total_cnt++;
    if (ringing_vec !== 4'b0000) begin
      $display("FAIL weekday7: got ring=%b, want 0000", ringing_vec);
    end else pass_cnt++;
    set_time(8'd11, 8'd59, 8'd59, 3'd3);
    write_cfg(2'd1, 8'd12, 8'd0, 8'd0, 7'b0000010, 1'b1);
    set_time(8'd12, 8'd0, 8'd0, 3'd3);
    cycles(3);
    total_cnt++;
    if (ringing_vec !== 4'b0000) begin
      $display("FAIL mask_wrong_day: got ring=%b, want 0000", ringing_vec);
    end else pass_cnt++;
    tick = 1'b0;
    set_time(8'd12, 8'd0, 8'd0, 3'd1);
    cycles(2);
    total_cnt++;
    if (ringing_vec !== 4'b0000) begin
      $display("FAIL no_tick_no_match: got ring=%b, want 0000", ringing_vec);
    end else pass_cnt++;
    tick = 1'b1;
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b0010 || active_idx !== 2'd1) begin
      $display("FAIL mask_right_day: got ring=%b idx=%0d, want 0010 1", ringing_vec, active_idx);
    end else pass_cnt++;
    set_time(8'd12, 8'd0, 8'd1, 3'd1);
    tick = 1'b0;
    cycles(10);
    tick = 1'b1;
    cycles(59);
    total_cnt++;
    if (ringing_vec !== 4'b0010) begin
      $display("FAIL timeout_early: got ring=%b after 59 ticks, want 0010", ringing_vec);
    end else pass_cnt++;
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b0000 || alarm_buzzer !== 1'b0) begin
      $display("FAIL timeout: got ring=%b buz=%b after 60 ticks, want 0000 0", ringing_vec, alarm_buzzer);
    end else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    set_time(8'd17, 8'd59, 8'd59, 3'd4);
    write_cfg(2'd0, 8'd18, 8'd0, 8'd0, 7'h7F, 1'b1);
    write_cfg(2'd3, 8'd18, 8'd0, 8'd0, 7'h7F, 1'b1);
    set_time(8'd18, 8'd0, 8'd0, 3'd4);
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b1001 || active_idx !== 2'd0 || alarm_buzzer !== 1'b1) begin
      $display("FAIL dual_fire: got ring=%b idx=%0d buz=%b, want 1001 0 1",
               ringing_vec, active_idx, alarm_buzzer);
    end else pass_cnt++;
    set_time(8'd18, 8'd0, 8'd1, 3'd4);
    snooze = 1'b1;
    stop = 1'b1;
    cycle();
    snooze = 1'b0;
    stop = 1'b0;
    total_cnt++;
    if (ringing_vec !== 4'b0000 || snoozed_vec !== 4'b0000 || alarm_buzzer !== 1'b0) begin
      $display("FAIL stop_wins: got ring=%b snz=%b buz=%b, want 0000 0000 0",
               ringing_vec, snoozed_vec, alarm_buzzer);
    end else pass_cnt++;
  endtask

  task automatic test_reset_cfg();
    set_time(8'd18, 8'd0, 8'd0, 3'd5);
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b1001) begin
      $display("FAIL refire: got ring=%b, want 1001", ringing_vec);
    end else pass_cnt++;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total_cnt++;
    if ({ringing_vec, snoozed_vec, alarm_buzzer, active_idx} !== 11'd0) begin
      $display("FAIL async_reset: got ring=%b buz=%b idx=%0d, want all 0",
               ringing_vec, alarm_buzzer, active_idx);
    end else pass_cnt++;
    #2 reset = 1'b0;
    cycles(2);
    total_cnt++;
    if (ringing_vec !== 4'b0000) begin
      $display("FAIL cfg_cleared: got ring=%b at old alarm time, want 0000", ringing_vec);
    end else pass_cnt++;
    set_time(8'd9, 8'd59, 8'd59, 3'd0);
    write_cfg(2'd3, 8'd10, 8'd0, 8'd0, 7'h7F, 1'b1);
    set_time(8'd10, 8'd0, 8'd0, 3'd0);
    cycle();
    total_cnt++;
    if (ringing_vec !== 4'b1000 || active_idx !== 2'd3) begin
      $display("FAIL idx3_fire: got ring=%b idx=%0d, want 1000 3", ringing_vec, active_idx);
    end else pass_cnt++;
    total_cnt++;
    if (ringing_vec3 !== 3'b000 || alarm_buzzer3 !== 1'b0) begin
      $display("FAIL out_of_range_write: got ring=%b buz=%b, want 000 0", ringing_vec3, alarm_buzzer3);
    end else pass_cnt++;
    set_time(8'd10, 8'd0, 8'd1, 3'd0);
    write_cfg(2'd3, 8'd10, 8'd0, 8'd0, 7'h7F, 1'b0);
    total_cnt++;
    if (ringing_vec !== 4'b0000 || alarm_buzzer !== 1'b0) begin
      $display("FAIL cfg_override: got ring=%b buz=%b, want 0000 0", ringing_vec, alarm_buzzer);
    end else pass_cnt++;
    set_time(8'd10, 8'd0, 8'd0, 3'd0);
    cycles(2);
    total_cnt++;
    if (ringing_vec !== 4'b0000) begin
      $display("FAIL disabled_idle: got ring=%b, want 0000", ringing_vec);
    end else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_fire();
    test_snooze();
    test_snooze_limit();
    test_weekday_timeout();
    test_simultaneous();
    test_reset_cfg();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
